// File: rtl/morse_symbol_decoder_if.sv
// Character stream handshake between the Morse decoder
// and the display/UART consumer.
interface morse_symbol_decoder_if;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_data,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_data,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/morse_symbol_decoder.sv
// Morse symbol accumulator, two-stage ASCII decode and
// first-word-fall-through character FIFO.
module morse_symbol_decoder #(
  parameter int MAX_SYMBOLS = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             dotOrDash,
  morse_symbol_decoder_if.master char_if,
  output logic [2:0]             symbol_count,
  output logic                   drop_flag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic       ovf;
    logic [2:0] cnt;
    logic [4:0] pat;
  } s1_t;

  logic [1:0] prev_q;
  logic       ev;
  logic       is_sym;
  logic       is_send;

  logic [4:0] pat_q, pat_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  s1_t        s1_q;
  logic       s1_valid_q;
  logic [7:0] s2_ch_q;
  logic       s2_valid_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] fcnt_q;
  logic          drop_q;
  logic          full;
  logic          push;
  logic          pop;

  assign ev      = (dotOrDash != prev_q) &&
                   (dotOrDash != 2'b00);
  assign is_send = ev && (dotOrDash == 2'b11);
  assign is_sym  = ev && (dotOrDash != 2'b11);

  always_comb begin
    pat_d = pat_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (is_send) begin
      pat_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (is_sym) begin
      if (cnt_q < 3'(MAX_SYMBOLS)) begin
        pat_d = {pat_q[3:0], dotOrDash[1]};
        cnt_d = cnt_q + 3'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 2'b00;
      pat_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= dotOrDash;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Key is {length, pattern}; first symbol sits at bit len-1.
  function automatic logic [7:0] lookup(s1_t s);
    logic [7:0] ch;
    ch = 8'h3F;
    if (s.cnt == 3'd0) begin
      ch = 8'h20;
    end else if (!s.ovf) begin
      case ({s.cnt, s.pat})
        {3'd2, 5'b00001}: ch = 8'h41;
        {3'd4, 5'b01000}: ch = 8'h42;
        {3'd4, 5'b01010}: ch = 8'h43;
        {3'd3, 5'b00100}: ch = 8'h44;
        {3'd1, 5'b00000}: ch = 8'h45;
        {3'd4, 5'b00010}: ch = 8'h46;
        {3'd3, 5'b00110}: ch = 8'h47;
        {3'd4, 5'b00000}: ch = 8'h48;
        {3'd2, 5'b00000}: ch = 8'h49;
        {3'd4, 5'b00111}: ch = 8'h4A;
        {3'd3, 5'b00101}: ch = 8'h4B;
        {3'd4, 5'b00100}: ch = 8'h4C;
        {3'd2, 5'b00011}: ch = 8'h4D;
        {3'd2, 5'b00010}: ch = 8'h4E;
        {3'd3, 5'b00111}: ch = 8'h4F;
        {3'd4, 5'b00110}: ch = 8'h50;
        {3'd4, 5'b01101}: ch = 8'h51;
        {3'd3, 5'b00010}: ch = 8'h52;
        {3'd3, 5'b00000}: ch = 8'h53;
        {3'd1, 5'b00001}: ch = 8'h54;
        {3'd3, 5'b00001}: ch = 8'h55;
        {3'd4, 5'b00001}: ch = 8'h56;
        {3'd3, 5'b00011}: ch = 8'h57;
        {3'd4, 5'b01001}: ch = 8'h58;
        {3'd4, 5'b01011}: ch = 8'h59;
        {3'd4, 5'b01100}: ch = 8'h5A;
        {3'd5, 5'b11111}: ch = 8'h30;
        {3'd5, 5'b01111}: ch = 8'h31;
        {3'd5, 5'b00111}: ch = 8'h32;
        {3'd5, 5'b00011}: ch = 8'h33;
        {3'd5, 5'b00001}: ch = 8'h34;
        {3'd5, 5'b00000}: ch = 8'h35;
        {3'd5, 5'b10000}: ch = 8'h36;
        {3'd5, 5'b11000}: ch = 8'h37;
        {3'd5, 5'b11100}: ch = 8'h38;
        {3'd5, 5'b11110}: ch = 8'h39;
        default:          ch = 8'h3F;
      endcase
    end
    return ch;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_ch_q    <= 8'h00;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= is_send;
      if (is_send) begin
        s1_q <= '{ovf: ovf_q, cnt: cnt_q, pat: pat_q};
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ch_q <= lookup(s1_q);
      end
    end
  end

  assign full = (fcnt_q == CW'(FIFO_DEPTH));
  assign pop  = char_if.char_valid && char_if.char_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push = s2_valid_q && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= s2_ch_q;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      if (push && !pop) begin
        fcnt_q <= fcnt_q + CW'(1);
      end else if (pop && !push) begin
        fcnt_q <= fcnt_q - CW'(1);
      end
      if (s2_valid_q && !push) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign char_if.char_valid = (fcnt_q != '0);
  assign char_if.char_data  = (fcnt_q != '0) ?
                              mem_q[rd_q] : 8'h00;
  assign symbol_count       = cnt_q;
  assign drop_flag          = drop_q;

endmodule
